// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone slave register memory behind the AHB-to-WB bridge.
// Single WB read/write cycles go to a 2^ADDR_WIDTH x DATA_WIDTH register array.
// Each accepted request is acknowledged with one wb_ack pulse after WAIT_STATES cycles.
// Optional feature macro: WB_SLAVE_MEM_STATS_EN adds saturating wr_count/rd_count outputs.
module wb_slave_mem #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int WAIT_STATES = 1,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data_in,
   output logic [DATA_WIDTH-1:0] wb_data_out,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   output logic                  wb_ack
`ifdef WB_SLAVE_MEM_STATS_EN
   ,
   output logic [15:0]           wr_count,
   output logic [15:0]           rd_count
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_HOLD
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic                  cap_we;
   logic [DATA_WIDTH-1:0] cap_data;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  request;
   logic                  capture;
   logic                  enter_ack;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic                  eff_we;
   logic [DATA_WIDTH-1:0] eff_data;

   assign request = wb_cyc & wb_stb;

   // State register; reset drops any in-flight transfer back to IDLE.
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: IDLE accepts, WAIT counts or aborts, ACK lasts one cycle, HOLD waits for request low.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (request) begin
               next_state = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!request) begin
               next_state = ST_IDLE;
            end else if (wait_cnt == 4'd0) begin
               next_state = ST_ACK;
            end
         end
         ST_ACK: begin
            next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (!request) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Access decode: with zero wait states the ack edge is the capture edge, so live inputs are used then.
   always_comb begin
      capture   = (state == ST_IDLE) && request;
      enter_ack = (next_state == ST_ACK);
      eff_addr  = capture ? wb_addr    : cap_addr;
      eff_we    = capture ? wb_we      : cap_we;
      eff_data  = capture ? wb_data_in : cap_data;
   end

   // Holding registers and wait counter; the bridge re-drives the bus, so only captured values matter later.
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         cap_addr <= '0;
         cap_we   <= 1'b0;
         cap_data <= '0;
         wait_cnt <= 4'd0;
      end else if (capture) begin
         cap_addr <= wb_addr;
         cap_we   <= wb_we;
         cap_data <= wb_data_in;
         wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && request && (wait_cnt != 4'd0)) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Registered ack pulse and read data, which holds until the next read ack or reset.
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         wb_ack      <= 1'b0;
         wb_data_out <= '0;
      end else begin
         wb_ack <= enter_ack;
         if (enter_ack && !eff_we) begin
            wb_data_out <= mem[eff_addr];
         end
      end
   end

   // Register array; a write commits only on the edge that raises the ack.
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_VALUE;
         end
      end else if (enter_ack && eff_we) begin
         mem[eff_addr] <= eff_data;
      end
   end

`ifdef WB_SLAVE_MEM_STATS_EN
   // Saturating transfer counters, bumped on the edge each ack rises.
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         wr_count <= 16'd0;
         rd_count <= 16'd0;
      end else if (enter_ack) begin
         if (eff_we && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
         if (!eff_we && (rd_count != 16'hFFFF)) begin
            rd_count <= rd_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: randomized bench for wb_slave_mem against an array-based reference model.
// The model tracks array contents, last read value and transfer counts from the bus rules.
// Optional feature macro: WB_SLAVE_MEM_STATS_EN enables the wr_count/rd_count checks.
module tb_wb_slave_mem;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int WS = 1;
   localparam logic [DW-1:0] RV = 8'h00;

   logic          wb_clk = 1'b0;
   logic          wb_rst = 1'b0;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data_in = '0;
   logic [DW-1:0] wb_data_out;
   logic          wb_cyc = 1'b0;
   logic          wb_stb = 1'b0;
   logic          wb_we = 1'b0;
   logic          wb_ack;
`ifdef WB_SLAVE_MEM_STATS_EN
   logic [15:0]   wr_count;
   logic [15:0]   rd_count;
`endif

   int            numChecks = 0;
   int            numBad = 0;
   logic [DW-1:0] memModel [2**AW];
   logic [DW-1:0] lastRead;
   int            wrModel;
   int            rdModel;

   wb_slave_mem #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .WAIT_STATES(WS),
      .RESET_VALUE(RV)
   ) dut (
      .wb_clk(wb_clk),
      .wb_rst(wb_rst),
      .wb_addr(wb_addr),
      .wb_data_in(wb_data_in),
      .wb_data_out(wb_data_out),
      .wb_cyc(wb_cyc),
      .wb_stb(wb_stb),
      .wb_we(wb_we),
      .wb_ack(wb_ack)
`ifdef WB_SLAVE_MEM_STATS_EN
      ,
      .wr_count(wr_count),
      .rd_count(rd_count)
`endif
   );

   // Free-running bus clock.
   always #5 wb_clk = ~wb_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numBad++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge wb_clk);
      #1;
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_ack"}, 32'(wb_ack), 32'd0);
      checkOutput({tag, "_dout"}, 32'(wb_data_out), 32'(lastRead));
   endtask

   task automatic resetModel;
      for (int i = 0; i < 2**AW; i++) memModel[i] = RV;
      lastRead = '0;
      wrModel = 0;
      rdModel = 0;
   endtask

   // One complete transfer: request, optional bus re-drive after capture, ack check, stb extension, release.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input int ext, input logic useAlt,
                                input logic [AW-1:0] altAddr, input logic [DW-1:0] altData);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we = we;
      wb_addr = addr;
      wb_data_in = data;
      for (int k = 0; k <= WS; k++) begin
         tick;
         if (k == 0 && useAlt) begin
            wb_addr = altAddr;
            wb_data_in = altData;
         end
         if (k == WS) begin
            if (we) begin
               memModel[addr] = data;
               wrModel++;
            end else begin
               lastRead = memModel[addr];
               rdModel++;
            end
            checkOutput("ack_rise", 32'(wb_ack), 32'd1);
            checkOutput("ack_dout", 32'(wb_data_out), 32'(lastRead));
         end else begin
            checkQuiet("ack_early");
         end
      end
      for (int e = 0; e < ext; e++) begin
         tick;
         checkQuiet("stb_ext");
      end
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_addr = AW'($urandom);
      wb_data_in = DW'($urandom);
      tick;
      checkQuiet("release1");
      tick;
      checkQuiet("release2");
   endtask

   // Request that is withdrawn during the wait states; nothing may be written or acknowledged.
   task automatic abortStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we = we;
      wb_addr = addr;
      wb_data_in = data;
      tick;
      checkQuiet("abort_req");
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      tick;
      checkQuiet("abort_drop");
      tick;
      checkQuiet("abort_idle");
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed cases, random traffic, mid-transfer reset, stats.
   initial begin
      logic          rwe;
      logic [AW-1:0] raddr;
      logic [DW-1:0] rdata;

      resetModel();
      wb_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         checkQuiet("in_reset");
      end
      wb_rst = 1'b1;
      tick;
      checkQuiet("post_reset");

      for (int a = 0; a < 2**AW; a++) applyStimulus(1'b0, AW'(a), 8'h00, 0, 1'b0, '0, '0);

      applyStimulus(1'b1, 2'd2, 8'hA5, 0, 1'b0, '0, '0);
      applyStimulus(1'b1, 2'd1, 8'h3C, 0, 1'b0, '0, '0);
      applyStimulus(1'b0, 2'd2, 8'h00, 0, 1'b0, '0, '0);
      applyStimulus(1'b0, 2'd1, 8'h00, 0, 1'b0, '0, '0);

      applyStimulus(1'b1, 2'd2, 8'h11, 0, 1'b1, 2'd3, 8'h22);
      applyStimulus(1'b0, 2'd2, 8'h00, 0, 1'b0, '0, '0);
      applyStimulus(1'b0, 2'd3, 8'h00, 0, 1'b0, '0, '0);

      abortStimulus(1'b1, 2'd1, 8'h77);
      applyStimulus(1'b0, 2'd1, 8'h00, 0, 1'b0, '0, '0);

      applyStimulus(1'b1, 2'd0, 8'h5A, 2, 1'b0, '0, '0);
      applyStimulus(1'b0, 2'd0, 8'h00, 2, 1'b0, '0, '0);

      for (int n = 0; n < 150; n++) begin
         rwe = 1'($urandom);
         raddr = AW'($urandom);
         rdata = DW'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            abortStimulus(rwe, raddr, rdata);
         end else begin
            applyStimulus(rwe, raddr, rdata, int'($urandom_range(0, 2)), 1'($urandom),
                          AW'($urandom), DW'($urandom));
         end
      end

`ifdef WB_SLAVE_MEM_STATS_EN
      checkOutput("wr_count_rand", 32'(wr_count), 32'(wrModel));
      checkOutput("rd_count_rand", 32'(rd_count), 32'(rdModel));
`endif

      applyStimulus(1'b1, 2'd3, 8'hC3, 0, 1'b0, '0, '0);
      applyStimulus(1'b0, 2'd3, 8'h00, 0, 1'b0, '0, '0);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we = 1'b1;
      wb_addr = 2'd3;
      wb_data_in = 8'h99;
      tick;
      checkQuiet("mid_req");
      wb_rst = 1'b0;
      #1;
      checkOutput("mid_rst_ack", 32'(wb_ack), 32'd0);
      checkOutput("mid_rst_dout", 32'(wb_data_out), 32'd0);
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      resetModel();
      tick;
      checkQuiet("mid_rst_hold1");
      tick;
      checkQuiet("mid_rst_hold2");
      wb_rst = 1'b1;
      tick;
      checkQuiet("mid_rst_rel");
`ifdef WB_SLAVE_MEM_STATS_EN
      checkOutput("wr_count_rst", 32'(wr_count), 32'd0);
      checkOutput("rd_count_rst", 32'(rd_count), 32'd0);
`endif

      applyStimulus(1'b0, 2'd3, 8'h00, 0, 1'b0, '0, '0);
      applyStimulus(1'b1, 2'd0, 8'h12, 1, 1'b0, '0, '0);
      applyStimulus(1'b1, 2'd1, 8'h34, 0, 1'b0, '0, '0);
      applyStimulus(1'b1, 2'd3, 8'h56, 2, 1'b0, '0, '0);
      applyStimulus(1'b0, 2'd1, 8'h00, 0, 1'b0, '0, '0);
`ifdef WB_SLAVE_MEM_STATS_EN
      checkOutput("wr_count", 32'(wr_count), 32'd3);
      checkOutput("rd_count", 32'(rd_count), 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", numChecks, numBad);
      $finish;
   end

endmodule
